// File: rtl/calc_pkg.sv
// Shared definitions for the calculator command driver: data width, opcodes,
// FSM state encoding and the queued command record.
package calc_pkg;

  localparam int DATA_W = 16;
  localparam int OP_W   = 3;

  typedef enum logic [OP_W-1:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_MUL = 3'b010,
    OP_DIV = 3'b011,
    OP_EXP = 3'b100,
    OP_LOG = 3'b101,
    OP_POW = 3'b110,
    OP_MOD = 3'b111
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_e;

  typedef struct packed {
    op_e               op;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
  } cmd_t;

  localparam int CMD_W = $bits(cmd_t);

endpackage

// File: rtl/calc_cmd_fifo.sv
// Command queue: FIFO_DEPTH entries of op+A+B, head visible combinationally.
// Full/empty come straight from the count register; pushes when full and pops when empty are dropped.
module calc_cmd_fifo
  import calc_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int WIDTH      = CMD_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_dat_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] head_dat_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] cnt_q;
  logic             do_push;
  logic             do_pop;

  assign full_o     = (cnt_q == CNT_W'(FIFO_DEPTH));
  assign empty_o    = (cnt_q == '0);
  assign do_push    = push_i && !full_o;
  assign do_pop     = pop_i && !empty_o;
  assign head_dat_o = mem_q[rd_ptr_q];

  // Depth is a power of two, so pointers wrap by plain overflow.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (do_push && !do_pop)      cnt_q <= cnt_q + 1'b1;
      else if (!do_push && do_pop) cnt_q <= cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_dat_i;
  end

endmodule

// File: rtl/calc_cmd_driver.sv
// Queues calculator commands and runs them one at a time: push->calc_enable 2 cycles, calc_done->rsp_valid 1 cycle;
// response held until rsp_ready, cmd_ready = !full. CALC_DRV_TIMEOUT_EN adds a WAIT timeout of TIMEOUT_CYCLES.
module calc_cmd_driver
  import calc_pkg::*;
#(
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [OP_W-1:0]   cmd_op,
  input  logic [DATA_W-1:0] cmd_a,
  input  logic [DATA_W-1:0] cmd_b,
  output logic              calc_enable,
  output logic [OP_W-1:0]   calc_operation,
  output logic [DATA_W-1:0] calc_opa,
  output logic [DATA_W-1:0] calc_opb,
  input  logic              calc_done,
  input  logic [DATA_W-1:0] calc_result,
  input  logic              calc_sign,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_sign,
  output logic [OP_W-1:0]   rsp_op,
  output logic              rsp_timeout,
  output logic              busy
);

  if (FIFO_DEPTH < 2 || FIFO_DEPTH > 16 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 ||
      TIMEOUT_CYCLES < 1) begin : g_bad_cfg
    $error("calc_cmd_driver: unsupported FIFO_DEPTH or TIMEOUT_CYCLES");
  end

  state_e            state_q;
  logic              en_q;
  op_e               op_q;
  logic [DATA_W-1:0] opa_q;
  logic [DATA_W-1:0] opb_q;
  logic              rsp_vld_q;
  logic [DATA_W-1:0] rsp_dat_q;
  logic              rsp_sign_q;
  op_e               rsp_op_q;

  cmd_t              push_dat;
  cmd_t              head;
  logic [CMD_W-1:0]  head_raw;
  logic              fifo_full;
  logic              fifo_empty;
  logic              pop;

  assign push_dat = '{op: op_e'(cmd_op), a: cmd_a, b: cmd_b};
  assign head     = cmd_t'(head_raw);
  assign pop      = (state_q == ST_IDLE) && !fifo_empty;

  calc_cmd_fifo #(
    .FIFO_DEPTH (FIFO_DEPTH),
    .WIDTH      (CMD_W)
  ) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .push_i     (cmd_valid),
    .push_dat_i (push_dat),
    .pop_i      (pop),
    .head_dat_o (head_raw),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty)
  );

`ifdef CALC_DRV_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TO_W-1:0] to_cnt_q;
  logic            rsp_to_q;
  assign rsp_timeout = rsp_to_q;
`else
  assign rsp_timeout = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      en_q       <= 1'b0;
      op_q       <= OP_ADD;
      opa_q      <= '0;
      opb_q      <= '0;
      rsp_vld_q  <= 1'b0;
      rsp_dat_q  <= '0;
      rsp_sign_q <= 1'b0;
      rsp_op_q   <= OP_ADD;
`ifdef CALC_DRV_TIMEOUT_EN
      to_cnt_q   <= '0;
      rsp_to_q   <= 1'b0;
`endif
    end else begin
      en_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (!fifo_empty) begin
            op_q    <= head.op;
            opa_q   <= head.a;
            opb_q   <= head.b;
            en_q    <= 1'b1;
            state_q <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
`ifdef CALC_DRV_TIMEOUT_EN
          to_cnt_q <= '0;
`endif
          state_q <= ST_WAIT;
        end
        ST_WAIT: begin
          // calc_done is checked first so a result arriving on the expiry cycle wins.
          if (calc_done) begin
            rsp_dat_q  <= calc_result;
            rsp_sign_q <= calc_sign;
            rsp_op_q   <= op_q;
            rsp_vld_q  <= 1'b1;
`ifdef CALC_DRV_TIMEOUT_EN
            rsp_to_q   <= 1'b0;
`endif
            state_q    <= ST_RESP;
          end
`ifdef CALC_DRV_TIMEOUT_EN
          else if (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
            rsp_dat_q  <= '0;
            rsp_sign_q <= 1'b0;
            rsp_op_q   <= op_q;
            rsp_vld_q  <= 1'b1;
            rsp_to_q   <= 1'b1;
            state_q    <= ST_RESP;
          end else begin
            to_cnt_q <= to_cnt_q + 1'b1;
          end
`endif
        end
        ST_RESP: begin
          if (rsp_ready) begin
            rsp_vld_q <= 1'b0;
            state_q   <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign cmd_ready      = !fifo_full;
  assign calc_enable    = en_q;
  assign calc_operation = op_q;
  assign calc_opa       = opa_q;
  assign calc_opb       = opb_q;
  assign rsp_valid      = rsp_vld_q;
  assign rsp_data       = rsp_dat_q;
  assign rsp_sign       = rsp_sign_q;
  assign rsp_op         = rsp_op_q;
  assign busy           = (state_q != ST_IDLE) || !fifo_empty;

endmodule

// File: tb/tb_calc_cmd_driver.sv
// Directed bench for calc_cmd_driver (FIFO_DEPTH=4, TIMEOUT_CYCLES=8); expected values are hand-computed.
module tb_calc_cmd_driver;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [2:0]  cmd_op = 3'd0;
  logic [15:0] cmd_a = 16'd0;
  logic [15:0] cmd_b = 16'd0;
  logic        calc_enable;
  logic [2:0]  calc_operation;
  logic [15:0] calc_opa;
  logic [15:0] calc_opb;
  logic        calc_done = 1'b0;
  logic [15:0] calc_result = 16'd0;
  logic        calc_sign = 1'b0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [15:0] rsp_data;
  logic        rsp_sign;
  logic [2:0]  rsp_op;
  logic        rsp_timeout;
  logic        busy;

  int tests = 0;
  int fails = 0;

  calc_cmd_driver #(.FIFO_DEPTH(4), .TIMEOUT_CYCLES(8)) dut (
    .clk            (clk),
    .reset          (reset),
    .cmd_valid      (cmd_valid),
    .cmd_ready      (cmd_ready),
    .cmd_op         (cmd_op),
    .cmd_a          (cmd_a),
    .cmd_b          (cmd_b),
    .calc_enable    (calc_enable),
    .calc_operation (calc_operation),
    .calc_opa       (calc_opa),
    .calc_opb       (calc_opb),
    .calc_done      (calc_done),
    .calc_result    (calc_result),
    .calc_sign      (calc_sign),
    .rsp_valid      (rsp_valid),
    .rsp_ready      (rsp_ready),
    .rsp_data       (rsp_data),
    .rsp_sign       (rsp_sign),
    .rsp_op         (rsp_op),
    .rsp_timeout    (rsp_timeout),
    .busy           (busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_enable(input string tag);
    for (int n = 0; n < 20 && calc_enable !== 1'b1; n++) tick();
    chk(tag, {63'd0, calc_enable}, 64'd1);
  endtask

  // Serve one queued command: see its issue, return a result, take the response.
  task automatic serve(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                       input logic [15:0] res);
    wait_enable("q_enable");
    chk("q_issue", {calc_operation, calc_opa, calc_opb}, {op, a, b});
    tick();
    calc_done = 1'b1; calc_result = res; calc_sign = 1'b0;
    tick();
    calc_done = 1'b0;
    chk("q_rsp", {rsp_valid, rsp_op, rsp_data, rsp_timeout}, {1'b1, op, res, 1'b0});
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk("q_rsp_clr", {63'd0, rsp_valid}, 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset values
    tick(); tick();
    chk("rst_outputs",
        {cmd_ready, calc_enable, calc_operation, calc_opa, calc_opb, rsp_valid,
         rsp_data, rsp_sign, rsp_op, rsp_timeout, busy},
        {1'b1, 59'd0});
    reset = 1'b0;
    tick();
    chk("idle_ready", {62'd0, cmd_ready, busy}, {62'd0, 1'b1, 1'b0});

    // Stray calc_done while idle and empty
    calc_done = 1'b1; calc_result = 16'hBEEF;
    tick();
    calc_done = 1'b0;
    chk("stray_done", {rsp_valid, calc_enable, busy, rsp_data}, {3'b000, 16'h0000});
    tick();
    chk("stray_done2", {rsp_valid, calc_enable, busy}, 3'b000);

    // Single add 3+4 into idle
    cmd_valid = 1'b1; cmd_op = 3'b000; cmd_a = 16'h0003; cmd_b = 16'h0004;
    tick();
    cmd_valid = 1'b0;
    chk("add_lat1", {calc_enable, busy}, 2'b01);
    tick();
    chk("add_issue", {calc_enable, calc_operation, calc_opa, calc_opb},
        {1'b1, 3'b000, 16'h0003, 16'h0004});
    tick();
    chk("add_wait", {calc_enable, rsp_valid, busy}, 3'b001);
    calc_done = 1'b1; calc_result = 16'h0007; calc_sign = 1'b0;
    tick();
    calc_done = 1'b0;
    chk("add_rsp", {rsp_valid, rsp_data, rsp_op, rsp_sign, rsp_timeout},
        {1'b1, 16'h0007, 3'b000, 1'b0, 1'b0});
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk("add_done", {rsp_valid, busy, calc_opa}, {2'b00, 16'h0003});

    // Held response: sub result held 10 cycles while a mul is queued behind it
    cmd_valid = 1'b1; cmd_op = 3'b001; cmd_a = 16'h0003; cmd_b = 16'h000A;
    tick();
    cmd_valid = 1'b0;
    tick();
    chk("sub_issue", {calc_enable, calc_operation}, {1'b1, 3'b001});
    tick();
    calc_done = 1'b1; calc_result = 16'h0007; calc_sign = 1'b1;
    tick();
    calc_done = 1'b0; calc_sign = 1'b0; calc_result = 16'h5555;
    cmd_valid = 1'b1; cmd_op = 3'b010; cmd_a = 16'h0005; cmd_b = 16'h0006;
    for (int i = 0; i < 10; i++) begin
      chk("hold_rsp", {rsp_valid, rsp_sign, rsp_op, rsp_data, calc_enable, calc_opa},
          {1'b1, 1'b1, 3'b001, 16'h0007, 1'b0, 16'h0003});
      tick();
      cmd_valid = 1'b0;
    end
    rsp_ready = 1'b1;
    tick();
    chk("hold_one_hs", {rsp_valid, calc_enable, busy}, 3'b001);
    tick();
    rsp_ready = 1'b0;
    chk("mul_issue", {calc_enable, calc_operation, calc_opa, calc_opb},
        {1'b1, 3'b010, 16'h0005, 16'h0006});
    tick();
    calc_done = 1'b1; calc_result = 16'h001E;
    tick();
    calc_done = 1'b0;
    chk("mul_rsp", {rsp_valid, rsp_op, rsp_data, rsp_sign}, {1'b1, 3'b010, 16'h001E, 1'b0});
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk("mul_done", {rsp_valid, busy}, 2'b00);

    // Five back-to-back pushes with the calculator stalled
    for (int i = 0; i < 5; i++) begin
      cmd_valid = 1'b1; cmd_op = 3'(i); cmd_a = 16'h0010 + 16'(i); cmd_b = 16'h0020 + 16'(i);
      chk("burst_ready", {63'd0, cmd_ready}, 64'd1);
      if (i == 2) chk("burst_issue0", {calc_enable, calc_opa}, {1'b1, 16'h0010});
      tick();
    end
    cmd_valid = 1'b1; cmd_op = 3'b111; cmd_a = 16'hDEAD; cmd_b = 16'hDEAD;
    chk("burst_full", {cmd_ready, busy}, 2'b01);
    tick();
    cmd_valid = 1'b0;
    chk("burst_still_full", {63'd0, cmd_ready}, 64'd0);
    calc_done = 1'b1; calc_result = 16'h0100;
    tick();
    calc_done = 1'b0;
    chk("burst_rsp0", {rsp_valid, rsp_op, rsp_data}, {1'b1, 3'd0, 16'h0100});
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    for (int k = 1; k < 5; k++) begin
      serve(3'(k), 16'h0010 + 16'(k), 16'h0020 + 16'(k), 16'h0100 + 16'(k));
    end
    chk("burst_ready_back", {cmd_ready, busy}, 2'b10);
    tick(); tick();
    chk("burst_no_extra", {calc_enable, busy}, 2'b00);

    // Timeout behaviour (or indefinite wait in the default build)
    cmd_valid = 1'b1; cmd_op = 3'b011; cmd_a = 16'h0009; cmd_b = 16'h0003;
    tick();
    cmd_valid = 1'b0;
    tick();
    chk("to_issue", {calc_enable, calc_operation}, {1'b1, 3'b011});
`ifdef CALC_DRV_TIMEOUT_EN
    for (int i = 0; i < 8; i++) tick();
    chk("to_before", {63'd0, rsp_valid}, 64'd0);
    tick();
    chk("to_expire", {rsp_valid, rsp_timeout, rsp_data, rsp_sign, rsp_op},
        {1'b1, 1'b1, 16'h0000, 1'b0, 3'b011});
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    cmd_valid = 1'b1; cmd_op = 3'b111; cmd_a = 16'h000A; cmd_b = 16'h0003;
    tick();
    cmd_valid = 1'b0;
    tick();
    chk("race_issue", {calc_enable, calc_operation}, {1'b1, 3'b111});
    for (int i = 0; i < 8; i++) tick();
    chk("race_before", {63'd0, rsp_valid}, 64'd0);
    calc_done = 1'b1; calc_result = 16'h0001; calc_sign = 1'b0;
    tick();
    calc_done = 1'b0;
    chk("race_done_wins", {rsp_valid, rsp_timeout, rsp_data, rsp_op},
        {1'b1, 1'b0, 16'h0001, 3'b111});
`else
    for (int i = 0; i < 100; i++) tick();
    chk("no_timeout", {rsp_valid, rsp_timeout, busy}, 3'b001);
    calc_done = 1'b1; calc_result = 16'h0003;
    tick();
    calc_done = 1'b0;
    chk("late_done", {rsp_valid, rsp_timeout, rsp_data, rsp_op}, {1'b1, 1'b0, 16'h0003, 3'b011});
`endif
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk("to_cleanup", {rsp_valid, busy}, 2'b00);

    // Reset during WAIT with two commands queued
    for (int i = 0; i < 3; i++) begin
      cmd_valid = 1'b1; cmd_op = 3'b100; cmd_a = 16'h0040 + 16'(i); cmd_b = 16'h0001;
      tick();
    end
    cmd_valid = 1'b0;
    chk("rstmid_busy", {calc_opa, busy, rsp_valid}, {16'h0040, 2'b10});
    reset = 1'b1;
    tick();
    chk("rstmid_outputs",
        {cmd_ready, calc_enable, calc_operation, calc_opa, calc_opb, rsp_valid,
         rsp_data, rsp_sign, rsp_op, rsp_timeout, busy},
        {1'b1, 59'd0});
    reset = 1'b0;
    calc_done = 1'b1; calc_result = 16'hAAAA;
    tick();
    calc_done = 1'b0;
    chk("rstmid_stray", {rsp_valid, busy, calc_enable, rsp_data}, {3'b000, 16'h0000});
    tick(); tick();
    chk("rstmid_drained", {calc_enable, busy, cmd_ready}, 3'b001);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/calc_cmd_driver.md
CALC_CMD_DRIVER -- requirements
Module: calc_cmd_driver

Interface
REQ-001 Parameter FIFO_DEPTH, default 4: command FIFO entries; SHALL be a power of two, 2..16.
REQ-002 Parameter TIMEOUT_CYCLES, default 64: WAIT-state cycle limit; used only when CALC_DRV_TIMEOUT_EN is defined.
REQ-003 clk  in  1  rising-edge clock for all state.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 cmd_valid  in  1  upstream command valid.
REQ-006 cmd_ready  out  1  FIFO can accept a command.
REQ-007 cmd_op  in  3  opcode: 000 add, 001 sub, 010 mul, 011 div, 100 A*exp(B), 101 log_A(B), 110 A^B, 111 mod.
REQ-008 cmd_a / cmd_b  in  16  operands A and B.
REQ-009 calc_enable  out  1  one-cycle start strobe to the calculator.
REQ-010 calc_operation  out  3; calc_opa / calc_opb  out  16  operation and operands presented to the calculator.
REQ-011 calc_done  in  1  calculator result-valid pulse.
REQ-012 calc_result  in  16; calc_sign  in  1  calculator result and sign.
REQ-013 rsp_valid  out  1; rsp_ready  in  1  response handshake.
REQ-014 rsp_data  out  16; rsp_sign  out  1; rsp_op  out  3; rsp_timeout  out  1  response payload.
REQ-015 busy  out  1  high when the FSM is not in IDLE or the FIFO is not empty.

Function
REQ-016 A command SHALL be pushed when cmd_valid && cmd_ready; cmd_ready SHALL equal !full, registered, with no bypass on a same-cycle pop.
REQ-017 FIFO pointers SHALL wrap modulo FIFO_DEPTH; a count register of width log2(FIFO_DEPTH)+1 SHALL derive full and empty.
REQ-018 FSM states SHALL be IDLE, ISSUE, WAIT, RESP.
REQ-019 IDLE: if the FIFO is not empty, pop the head, register op/A/B onto calc_* outputs, go to ISSUE; otherwise stay.
REQ-020 ISSUE: calc_enable SHALL be 1 for exactly this one cycle; go to WAIT.
REQ-021 WAIT: on calc_done, capture calc_result/calc_sign/op into rsp_*, set rsp_timeout=0, go to RESP.
REQ-022 RESP: rsp_valid SHALL be 1 and payload stable until rsp_ready; on rsp_valid && rsp_ready go to IDLE.
REQ-023 Latency: a push into an empty FIFO with the FSM in IDLE SHALL produce calc_enable 2 cycles later; a response SHALL be issued 1 cycle after calc_done.
REQ-024 calc_done SHALL be ignored in IDLE, ISSUE and RESP.
REQ-025 calc_opa/opb/operation SHALL hold their values from the pop until the next pop.
REQ-026 Only one command SHALL be in flight; pushes SHALL continue during WAIT and RESP while not full.

Reset
REQ-027 reset SHALL empty the FIFO, force IDLE, clear the timeout counter and drive cmd_ready=1, calc_enable=0, calc_operation/opa/opb=0, rsp_valid=0, rsp_data=0, rsp_sign=0, rsp_op=0, rsp_timeout=0, busy=0.
REQ-028 reset mid-operation SHALL abandon the in-flight command, and a late calc_done SHALL be ignored per REQ-024.

Configuration
REQ-029 Macro CALC_DRV_TIMEOUT_EN: when defined, a counter SHALL run in WAIT; if it reaches TIMEOUT_CYCLES without calc_done, go to RESP with rsp_data=0, rsp_sign=0, rsp_timeout=1. calc_done in the same cycle as expiry SHALL win.
REQ-030 Without CALC_DRV_TIMEOUT_EN: no counter SHALL be present, WAIT SHALL wait indefinitely, and rsp_timeout SHALL be tied to 0.

Structure
REQ-031 Package calc_pkg SHALL hold the data width (16), opcode constants OP_ADD..OP_MOD, and the FSM state encoding.
REQ-032 The FIFO SHALL be sub-module calc_cmd_fifo (parameter FIFO_DEPTH, width 35 = op+A+B).

Verification
REQ-033 Push add A=0x0003 B=0x0004 into idle -> calc_enable 2 cycles later with calc_opa=3, calc_opb=4; calc_done with result 0x0007 -> rsp_valid next cycle, rsp_data=0x0007, rsp_op=000.
REQ-034 Push 5 commands back-to-back with calculator stalled and FIFO_DEPTH=4 -> cmd_ready=0 after 4 accepted (the 1st is popped, so the 5th is accepted 1 cycle later); responses in order.
REQ-035 Hold rsp_ready=0 for 10 cycles in RESP -> payload stable, no new calc_enable, then exactly one handshake.
REQ-036 With CALC_DRV_TIMEOUT_EN and TIMEOUT_CYCLES=8, no calc_done -> rsp_timeout=1, rsp_data=0 on the 9th cycle after ISSUE; calc_done at the expiry cycle -> rsp_timeout=0.
REQ-037 Assert reset during WAIT with 2 queued commands -> all outputs at reset values next cycle, a stray calc_done ignored, busy=0.
REQ-038 calc_done pulse while IDLE with empty FIFO -> no rsp_valid and no state change.
